serial_mantissa_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder for the fp16 MAC datapath. Instantiates a single

---
 rtl/serial_mantissa_adder.sv | 142 ++++++++++++++
 tb/tb_serial_mantissa_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mantissa_adder.sv
// Bit-serial WIDTH-bit mantissa adder: one full_adder cell iterated LSB-first, valid/ready on both sides.
// Optional subtract (a - b, cout = no borrow) enabled by defining SERIAL_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

module serial_mantissa_adder #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic             fa_sum_s;
  logic             fa_cout_s;

  // Operand conditioning at accept: subtraction is a + ~b + 1
  always_comb begin
`ifdef SERIAL_SUB_EN
    b_load_s     = sub ? ~b : b;
    carry_load_s = sub;
`else
    b_load_s     = b;
    carry_load_s = 1'b0;
`endif
  end

  full_adder u_fa (
    .a   (a_sr_r[0]),
    .b   (b_sr_r[0]),
    .cin (carry_r),
    .s   (fa_sum_s),
    .co  (fa_cout_s)
  );

  // Control FSM and serial datapath; handshake flags are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= '0;
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sr_r     <= a;
            b_sr_r     <= b_load_s;
            carry_r    <= carry_load_s;
            count_r    <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
          carry_r <= fa_cout_s;
          a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
          if (count_r == LAST) begin
            cout_r      <= fa_cout_s;
            out_valid_r <= 1'b1;
            count_r     <= '0;
            state_r     <= DONE;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          // No bypass: in_ready rises together with the return to IDLE
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_mantissa_adder.sv
// Scoreboard bench for serial_mantissa_adder: arithmetic reference model, decoupled driver and monitor.
// Define SERIAL_SUB_EN for both RTL and bench to exercise subtraction.

module tb_serial_mantissa_adder;

  localparam int W = 11;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           last_hs = 0;
  int           ordy_mode = 1;
  bit           prev_v = 1'b0;
  logic [W-1:0] held_s = '0;
  logic         held_c = 1'b0;

  always #5 clk = ~clk;

  serial_mantissa_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic void chk(string nm, longint act, longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference: {cout,sum} = a + b, or a + (2^W - b) when subtracting
  function automatic logic [W:0] ref_model(int ua, int ub, bit s);
    int r;
    if (s) r = ua + ((1 << W) - ub);
    else   r = ua + ub;
    return (W+1)'(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: latency, hold-under-backpressure, in_ready low while busy, result vs scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_low_in_done", longint'(in_ready), 0);
        if (!prev_v) begin
          if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
          else               chk("latency", cyc - q[0].acc, W);
        end else begin
          chk("hold_sum", longint'(sum), longint'(held_s));
          chk("hold_cout", longint'(cout), longint'(held_c));
        end
        held_s = sum;
        held_c = cout;
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("result_without_request", 1, 0);
          end else begin
            e = q.pop_front();
            chk("sum", longint'(sum), longint'(e.s));
            chk("cout", longint'(cout), longint'(e.c));
          end
          last_hs = cyc + 1;
        end
      end else if (q.size() > 0 && cyc >= q[0].acc) begin
        chk("in_ready_low_in_run", longint'(in_ready), 0);
      end
      prev_v = out_valid;
    end
  end

  // Driver: called at a negedge, returns at a negedge after the accept edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit ts, output int acc);
    logic [W:0] r;
    exp_t e;
    int n;
    in_valid = 1'b1;
    a = ta;
    b = tb;
`ifdef SERIAL_SUB_EN
    sub = ts;
`endif
    n = 0;
    acc = -1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    r = ref_model(int'(ta), int'(tb), ts && SUB_EN);
    e.s = r[W-1:0];
    e.c = r[W];
    e.acc = cyc + 1;
    acc = e.acc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
`ifdef SERIAL_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0 || out_valid) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int acc;
    int acc2;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_cout", longint'(cout), 0);
    rst = 1'b0;

    // Simple add and full carry ripple
    send(11'd3, 11'd5, 1'b0, acc);
    drain();
    send(11'h7FF, 11'h001, 1'b0, acc);
    drain();

    // Backpressure: result holds, new request blocked until after output handshake
    ordy_mode = 0;
    send(W'($urandom), W'($urandom), 1'b0, acc);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid_seen", longint'(out_valid), 1);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid_held", longint'(out_valid), 1);
      chk("bp_no_accept", longint'(in_ready), 0);
    end
    ordy_mode = 1;
    send(11'h123, 11'h456, 1'b0, acc);
    chk("accept_after_hs", acc - last_hs, 1);
    drain();

    // Back-to-back with in_valid held high
    send(11'h2AA, 11'h155, 1'b0, acc);
    send(11'h400, 11'h400, 1'b0, acc2);
    chk("b2b_accept", acc2 - last_hs, 1);
    drain();

    // Reset in the middle of RUN aborts the operation
    send(11'h0F0, 11'h00F, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_sum", longint'(sum), 0);
    chk("midrst_cout", longint'(cout), 0);
    rst = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      chk("midrst_no_valid", longint'(out_valid), 0);
    end
    send(11'd1, 11'd1, 1'b0, acc);
    drain();

    if (SUB_EN) begin
      send(11'd5, 11'd7, 1'b1, acc);
      send(11'd7, 11'd5, 1'b1, acc);
      send(11'd9, 11'd0, 1'b1, acc);
      drain();
    end

    // Randomised traffic with random backpressure and input gaps
    ordy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(W'($urandom), W'($urandom), SUB_EN && ($urandom_range(0, 1) == 1), acc);
    end
    ordy_mode = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
